matmul_host_ctrl: RTL
=====================

Name: matmul_host_ctrl

Overview:
Host-side sequencer that drives the write/readout ports of matrix_multiplication, the 4x4 systolic array top.
- Accepts a job as a stream of 2*N 64-bit words (A columns, then B rows) and writes them into the A/B RAMs.
- Pulses the array reset, raises start_mat_mul and waits for done_mat_mul.
- Sweeps out_sel over all N*N results and returns them on a valid/ready result stream.

Parameters:
DWIDTH, 16, operand width; result width is 2*DWIDTH
AWIDTH, 9, RAM address width
MEM_SIZE, 512, RAM depth; address MEM_SIZE-1 is the zero-padding word
N, 4, matrix dimension; fixed to the array size

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cfg_start  in  1  job start pulse; honoured only in IDLE
in_data  in  4*DWIDTH  load word; lane i = bits [DWIDTH*i+DWIDTH-1 : DWIDTH*i]
in_valid  in  1  load word valid
in_ready  out  1  load word accepted when in_valid & in_ready
res_data  out  2*DWIDTH  result C[r][c]
res_valid  out  1  result valid
res_ready  in  1  result accepted when res_valid & res_ready
res_last  out  1  high with C[N-1][N-1]
busy  out  1  high in every state except IDLE
mem_wr_en  out  1  to enable_writing_to_mem
mem_addr  out  AWIDTH  to addr_pi
mem_data  out  4*DWIDTH  to data_pi
we_a  out  1  A RAM write strobe
we_b  out  1  B RAM write strobe
mm_reset  out  1  to the array reset
start_mat_mul  out  1  to the array
done_mat_mul  in  1  from the array
out_sel  out  AWIDTH  to the array result select
data_out  in  2*DWIDTH  from the array; registered there, reflects the previous cycle's out_sel while done_mat_mul=1

Behaviour:
- All outputs are registered. Reset value of every output is 0, including out_sel and mem_addr. A reset in any state returns to IDLE on the next edge. RAM contents are not cleared.
- IDLE:
  - in_ready=0.
  - cfg_start=1 -> CLR.
- CLR (1 cycle): mem_wr_en=1, mem_addr=MEM_SIZE-1, mem_data=0, we_a=we_b=1, mm_reset=1 -> LOAD_A, cnt=0.
- LOAD_A:
  - in_ready=1.
  - Each handshake produces, on the next cycle: mem_wr_en=1, we_a=1, mem_addr=cnt, mem_data=in_data; then cnt++.
  - Word k is column k of A, lane i = A[i][k].
  - Beat N-1 -> LOAD_B with cnt=0.
  - No handshake -> we_a=0 that cycle; mem_wr_en stays 1.
- LOAD_B:
  - Same as LOAD_A with we_b.
  - Word k is row k of B, lane j = B[k][j].
  - Beat N-1 -> WR_FLUSH.
- WR_FLUSH: the last B write is presented; in_ready=0 -> RUN.
- RUN:
  - mem_wr_en=0, start_mat_mul=1.
  - done_mat_mul=1 -> DR_SEL with idx=0, out_sel=0.
- start_mat_mul stays 1 from RUN through all DR_* states.
- DR_SEL (1 cycle): out_sel=idx is stable; the array registers C[idx] -> DR_CAP.
- DR_CAP (1 cycle): res_data<=data_out, res_valid<=1, res_last<=(idx==N*N-1) -> DR_OUT.
- DR_OUT:
  - Hold res_data, res_valid and res_last stable until res_ready.
  - On handshake: res_valid<=0.
  - If idx==N*N-1 -> DONE; else idx++, out_sel<=idx+1, -> DR_SEL.
- DONE (1 cycle): start_mat_mul=0, busy=1 -> IDLE.
- Result order is row-major: idx = r*N + c. Minimum 3 cycles per result.
- Arithmetic: results are unsigned modulo 2^(2*DWIDTH), as the array produces them. The block does no arithmetic on data.
- Boundaries:
  - in_valid outside LOAD_A/LOAD_B is ignored.
  - cfg_start while busy is ignored.
  - res_ready while res_valid=0 has no effect.
  - in_valid low in a LOAD state causes no write and no address gap.
  - Back-to-back jobs are correct because CLR pulses mm_reset, which clears the PE accumulators.

Decomposition:
- Shared package matmul_pkg holds DWIDTH, AWIDTH, MEM_SIZE, N and the state enum: IDLE, CLR, LOAD_A, LOAD_B, WR_FLUSH, RUN, DR_SEL, DR_CAP, DR_OUT, DONE.
- No sub-module: a single FSM with cnt and idx counters.

Test Plan:
1. A=identity, B[r][c]=4r+c+1 -> res_data 1..16 in order; res_last only on the 16th; busy drops after DONE.
2. One job with in_valid always high -> the write trace is exactly:
   - addr 511 data 0 with we_a=we_b=1;
   - then we_a at addrs 0..3;
   - then we_b at addrs 0..3;
   - start_mat_mul rises the cycle after the last we_b.
3. in_valid low for 3 cycles between each load beat -> writes occur only on handshakes; addresses stay contiguous 0..3; results match case 1.
4. res_ready low 10 cycles at idx 5, then toggling -> res_data/res_valid stable while stalled; all 16 results in order, none lost or duplicated.
5. All A and B lanes 0xFFFF -> every result 0xFFF80004 (wraps mod 2^32).
6. Run two jobs back-to-back -> second results independent of the first. Then reset during LOAD_B -> next cycle all outputs 0, in_ready=0; a fresh job then returns correct results.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the systolic-array host sequencer.
package matmul_pkg;

    localparam int DWIDTH   = 16;
    localparam int AWIDTH   = 9;
    localparam int MEM_SIZE = 512;
    localparam int N        = 4;

    localparam int WW = N * DWIDTH;
    localparam int RW = 2 * DWIDTH;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N * N);

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        LOAD_A,
        LOAD_B,
        WR_FLUSH,
        RUN,
        DR_SEL,
        DR_CAP,
        DR_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/matmul_host_ctrl.sv
// Host sequencer: loads A/B RAMs, runs the 4x4 array, streams out C.
module matmul_host_ctrl
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [WW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RW-1:0]     res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_last,
    output logic              busy,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WW-1:0]     mem_data,
    output logic              we_a,
    output logic              we_b,
    output logic              mm_reset,
    output logic              start_mat_mul,
    input  logic              done_mat_mul,
    output logic [AWIDTH-1:0] out_sel,
    input  logic [RW-1:0]     data_out
);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    logic              in_ready_q, in_ready_d;
    logic [RW-1:0]     res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              res_last_q, res_last_d;
    logic              busy_q, busy_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WW-1:0]     mem_data_q, mem_data_d;
    logic              we_a_q, we_a_d;
    logic              we_b_q, we_b_d;
    logic              mm_reset_q, mm_reset_d;
    logic              start_q, start_d;
    logic [AWIDTH-1:0] out_sel_q, out_sel_d;

    logic in_hs, res_hs, last_beat, last_idx;

    // in_ready_q is high only in LOAD_A/LOAD_B, so in_hs is a load beat
    assign in_hs     = in_valid & in_ready_q;
    assign res_hs    = res_valid_q & res_ready;
    assign last_beat = (cnt_q == CW'(N - 1));
    assign last_idx  = (idx_q == IW'(N * N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            mm_reset_q  <= 1'b0;
            start_q     <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            we_a_q      <= we_a_d;
            we_b_q      <= we_b_d;
            mm_reset_q  <= mm_reset_d;
            start_q     <= start_d;
            out_sel_q   <= out_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE:     if (cfg_start) state_d = CLR;
            CLR: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
            LOAD_A: if (in_hs) begin
                cnt_d = cnt_q + 1'b1;
                if (last_beat) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end
            end
            LOAD_B: if (in_hs) begin
                cnt_d = cnt_q + 1'b1;
                if (last_beat) state_d = WR_FLUSH;
            end
            WR_FLUSH: state_d = RUN;
            RUN: if (done_mat_mul) begin
                state_d = DR_SEL;
                idx_d   = '0;
            end
            DR_SEL:   state_d = DR_CAP;
            DR_CAP:   state_d = DR_OUT;
            DR_OUT: if (res_hs) begin
                if (last_idx) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DR_SEL;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they register in step with it
    always_comb begin
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d      = (state_d != IDLE);
        mm_reset_d  = (state_d == CLR);
        mem_wr_en_d = (state_d inside {CLR, LOAD_A, LOAD_B, WR_FLUSH});
        start_d     = (state_d inside {RUN, DR_SEL, DR_CAP, DR_OUT});
        we_a_d      = 1'b0;
        we_b_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        if (state_d == CLR) begin
            we_a_d     = 1'b1;
            we_b_d     = 1'b1;
            mem_addr_d = AWIDTH'(MEM_SIZE - 1);
            mem_data_d = '0;
        end else if (in_hs) begin
            we_a_d     = (state_q == LOAD_A);
            we_b_d     = (state_q == LOAD_B);
            mem_addr_d = AWIDTH'(cnt_q);
            mem_data_d = in_data;
        end
        out_sel_d   = (state_d == DR_SEL) ? AWIDTH'(idx_d) : out_sel_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        if (state_q == DR_CAP) begin
            res_data_d  = data_out;
            res_valid_d = 1'b1;
            res_last_d  = last_idx;
        end else if (res_hs) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end
    end

    assign in_ready      = in_ready_q;
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;
    assign res_last      = res_last_q;
    assign busy          = busy_q;
    assign mem_wr_en     = mem_wr_en_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign we_a          = we_a_q;
    assign we_b          = we_b_q;
    assign mm_reset      = mm_reset_q;
    assign start_mat_mul = start_q;
    assign out_sel       = out_sel_q;

endmodule
